// File: rtl/rom_fetch_unit.sv
// Sequential ROM instruction prefetcher: issues word reads, tags them through a
// latency-matched pipe, buffers returned words and presents them as a valid/ready stream.
module rom_fetch_unit #(
    parameter int                ADDR_W       = 10,
    parameter int                DATA_W       = 32,
    parameter int                FIFO_DEPTH   = 4,
    parameter int                READ_LATENCY = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic                clk_fetch_clk,
    input  logic                rst_fetch_reset_n,
    input  logic                fetch_enable,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [DATA_W-1:0]   instr_data,
    output logic [ADDR_W-1:0]   instr_addr,
    output logic                busy,
    output logic [ADDR_W-1:0]   rom_address,
    output logic                rom_chipselect,
    output logic                rom_clken,
    output logic                rom_write,
    output logic [DATA_W-1:0]   rom_writedata,
    output logic [DATA_W/8-1:0] rom_byteenable,
    output logic                rom_debugaccess,
    input  logic [DATA_W-1:0]   rom_readdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT   = READ_LATENCY;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   pc;
    logic [LAT:0]        tag_valid;
    logic [ADDR_W-1:0]   tag_addr [0:LAT];
    logic [DATA_W-1:0]   data_mem [0:FIFO_DEPTH-1];
    logic [ADDR_W-1:0]   addr_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_count, inflight;
    logic                issue, capture, pop;

    always_ff @(posedge clk_fetch_clk or negedge rst_fetch_reset_n) begin
        if (!rst_fetch_reset_n) state <= IDLE;
        else                    state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fetch_enable)  next_state = RUN;
            RUN:     if (!fetch_enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Credit counts every outstanding tag, so a captured word always has a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) inflight = inflight + CNT_W'(tag_valid[i]);
        issue   = (state == RUN) && fetch_enable && !redirect_valid &&
                  (((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH));
        capture = tag_valid[LAT] && !redirect_valid;
        pop     = instr_valid && instr_ready;
    end

    always_ff @(posedge clk_fetch_clk or negedge rst_fetch_reset_n) begin
        if (!rst_fetch_reset_n) begin
            pc             <= RESET_PC;
            rom_address    <= '0;
            rom_chipselect <= 1'b0;
        end else begin
            rom_chipselect <= issue;
            if (issue) rom_address <= pc;
            if (redirect_valid) pc <= redirect_addr;
            else if (issue)     pc <= pc + 1'b1;
        end
    end

    // Stage 0 lines up with the chipselect cycle; stage LAT lines up with valid readdata.
    always_ff @(posedge clk_fetch_clk or negedge rst_fetch_reset_n) begin
        if (!rst_fetch_reset_n) begin
            tag_valid <= '0;
            for (int i = 0; i <= LAT; i++) tag_addr[i] <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_addr[0]  <= pc;
            for (int i = 1; i <= LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_addr[i]  <= tag_addr[i-1];
            end
            if (redirect_valid) tag_valid <= '0;
        end
    end

    // NOTE: the FIFO storage is reset too, so instr_data/instr_addr read 0 out of reset.
    always_ff @(posedge clk_fetch_clk or negedge rst_fetch_reset_n) begin
        if (!rst_fetch_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) begin
                data_mem[wr_ptr] <= rom_readdata;
                addr_mem[wr_ptr] <= tag_addr[LAT];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign instr_valid     = (fifo_count != '0);
    assign instr_data      = data_mem[rd_ptr];
    assign instr_addr      = addr_mem[rd_ptr];
    assign busy            = (inflight != '0) || (fifo_count != '0);
    assign rom_clken       = 1'b1;
    assign rom_write       = 1'b0;
    assign rom_writedata   = '0;
    assign rom_byteenable  = '1;
    assign rom_debugaccess = 1'b0;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: ROM model with ROM[i]=i*3, cycle-exact vector table,
// hand sequences for redirect, wrap, enable and async reset, plus an in-order pop monitor.
module tb_rom_fetch_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_enable, redirect_valid, instr_ready;
    logic [ADDR_W-1:0] redirect_addr;
    logic              instr_valid, busy;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic [ADDR_W-1:0] rom_address;
    logic              rom_chipselect, rom_clken, rom_write, rom_debugaccess;
    logic [DATA_W-1:0] rom_writedata, rom_readdata;
    logic [3:0]        rom_byteenable;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rom_fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .READ_LATENCY(1), .RESET_PC('0)
    ) dut (
        .clk_fetch_clk(clk),           .rst_fetch_reset_n(rst_n),
        .fetch_enable(fetch_enable),   .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready),     .instr_data(instr_data),
        .instr_addr(instr_addr),       .busy(busy),
        .rom_address(rom_address),     .rom_chipselect(rom_chipselect),
        .rom_clken(rom_clken),         .rom_write(rom_write),
        .rom_writedata(rom_writedata), .rom_byteenable(rom_byteenable),
        .rom_debugaccess(rom_debugaccess), .rom_readdata(rom_readdata)
    );

    // ROM slave model, read latency 1; garbage when not selected.
    always @(posedge clk)
        rom_readdata <= rom_chipselect ? 32'(rom_address) * 32'd3 : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted word must be the next address of the current stream with ROM data.
    logic [ADDR_W-1:0] exp_next;
    always @(negedge clk) begin
        if (!rst_n) exp_next = '0;
        else begin
            if (instr_valid && instr_ready) begin
                check("pop_addr", 32'(instr_addr), 32'(exp_next));
                check("pop_data", instr_data, 32'(exp_next) * 32'd3);
                exp_next = exp_next + 1'b1;
            end
            if (redirect_valid) exp_next = redirect_addr;
        end
    end

    typedef struct {
        logic              en;
        logic              rdy;
        logic              exp_valid;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_cs;
        logic              exp_busy;
    } vec_t;

    vec_t vecs [24];

    initial begin
        int n;

        // Cycle-exact fill, stall and drain; vector v is checked after the (v+1)th edge.
        for (int v = 0; v < 24; v++) begin
            vecs[v].en        = 1'b1;
            vecs[v].rdy       = !(v >= 8 && v <= 17);
            vecs[v].exp_valid = (v >= 3);
            vecs[v].exp_busy  = (v >= 1);
            if (v < 3)        vecs[v].exp_addr = '0;
            else if (v < 8)   vecs[v].exp_addr = ADDR_W'(v - 3);
            else if (v < 18)  vecs[v].exp_addr = 10'd4;
            else              vecs[v].exp_addr = ADDR_W'(v - 13);
            if (v == 0)                vecs[v].exp_cs = 1'b0;
            else if (v >= 8 && v < 18) vecs[v].exp_cs = (v == 8);
            else if (v == 18)          vecs[v].exp_cs = 1'b0;
            else                       vecs[v].exp_cs = 1'b1;
        end

        rst_n = 1'b0; fetch_enable = 1'b0; redirect_valid = 1'b0;
        redirect_addr = '0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cs", 32'(rom_chipselect), 0);
        check("rst_rom_addr", 32'(rom_address), 0);
        check("rst_data", instr_data, 0);
        check("const_clken", 32'(rom_clken), 1);
        check("const_write", 32'(rom_write), 0);
        check("const_be", 32'(rom_byteenable), 32'hF);
        check("const_wdata", rom_writedata, 0);
        check("const_dbg", 32'(rom_debugaccess), 0);
        rst_n = 1'b1;

        // Tests 1 and 2: steady stream, 10-cycle stall, drain.
        for (int v = 0; v < 24; v++) begin
            fetch_enable = vecs[v].en;
            instr_ready  = vecs[v].rdy;
            step();
            check($sformatf("vec%0d_valid", v), 32'(instr_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_cs", v), 32'(rom_chipselect), 32'(vecs[v].exp_cs));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_addr", v), 32'(instr_addr), 32'(vecs[v].exp_addr));
                check($sformatf("vec%0d_data", v), instr_data, 32'(vecs[v].exp_addr) * 32'd3);
            end
        end

        // Test 3: redirect with words both buffered and in flight.
        instr_ready = 1'b0;
        step();
        check("pre_redirect_busy", 32'(busy), 1);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 10'h200;
        step();
        redirect_valid = 1'b0;
        check("redir_valid0", 32'(instr_valid), 0);
        check("redir_no_issue", 32'(rom_chipselect), 0);
        step();
        check("redir_cs", 32'(rom_chipselect), 1);
        check("redir_rom_addr", 32'(rom_address), 32'h200);
        check("redir_valid1", 32'(instr_valid), 0);
        step();
        check("redir_valid2", 32'(instr_valid), 0);
        step();
        check("redir_first_valid", 32'(instr_valid), 1);
        check("redir_first_addr", 32'(instr_addr), 32'h200);
        check("redir_first_data", instr_data, 32'h600);
        repeat (3) step();

        // Test 4: address wrap.
        redirect_valid = 1'b1; redirect_addr = 10'h3FE;
        step();
        redirect_valid = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("wrap%0d_valid", k), 32'(instr_valid), 1);
            check($sformatf("wrap%0d_addr", k), 32'(instr_addr), 32'((10'h3FE + k) % 1024));
        end

        // Test 5: disable mid-stream, in-flight words still delivered, then resume.
        fetch_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("dis%0d_cs", k), 32'(rom_chipselect), 0);
        end
        check("dis_busy", 32'(busy), 0);
        check("dis_valid", 32'(instr_valid), 0);
        fetch_enable = 1'b1;
        n = 0;
        while (!instr_valid && n < 10) begin
            step();
            n++;
        end
        check("resume_timeout", 32'(n < 10), 1);
        check("resume_addr", 32'(instr_addr), 32'(exp_next));
        repeat (3) step();

        // Test 6: asynchronous reset between edges, then restart at address 0.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(instr_valid), 0);
        check("arst_cs", 32'(rom_chipselect), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rom_addr", 32'(rom_address), 0);
        check("arst_instr_addr", 32'(instr_addr), 0);
        check("arst_data", instr_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!instr_valid && n < 12) begin
            step();
            n++;
        end
        check("restart_latency", 32'(n), 4);
        check("restart_addr", 32'(instr_addr), 0);
        check("restart_data", instr_data, 0);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
